// File: rtl/riscv_axi_pkg.sv
// Shared definitions for the AXI4-lite master: response and error codes,
// protection defaults, access sizes and the controller state encoding.
package riscv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] INST_PROT = 3'b101;
    localparam logic [2:0] DATA_PROT = 3'b000;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAwW,
        StB,
        StErr,
        StRsp
    } state_e;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starting at the
// channel after the last one granted; the pointer moves only on i_advance.
module axi_rr_arbiter #(
    parameter int unsigned N_CH = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_req,
    input  logic            i_advance,
    output logic [N_CH-1:0] o_grant
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W:0]   w_sum;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_win   = r_ptr;
        w_idx   = '0;
        w_sum   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N_CH)) begin
                w_sum = w_sum - (PTR_W+1)'(N_CH);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_win          = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_win == PTR_W'(N_CH - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_master.sv
// Multi-channel AXI4-lite master: arbitrates requesters onto a single port with one
// transaction in flight, handles lane steering, load extension, errors and a watchdog.
module axi_lite_master
    import riscv_axi_pkg::*;
#(
    parameter int unsigned        N_CH    = 2,
    parameter int unsigned        ADDR_W  = 32,
    parameter int unsigned        DATA_W  = 32,
    parameter logic [3*N_CH-1:0]  CH_PROT = {DATA_PROT, INST_PROT},
    parameter int unsigned        TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_CH-1:0]        i_req_valid,
    output logic [N_CH-1:0]        o_req_ready,
    input  logic [N_CH-1:0]        i_req_write,
    input  logic [2*N_CH-1:0]      i_req_size,
    input  logic [N_CH-1:0]        i_req_signed,
    input  logic [N_CH*ADDR_W-1:0] i_req_addr,
    input  logic [N_CH*DATA_W-1:0] i_req_wdata,
    output logic [N_CH-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]      o_rsp_rdata,
    output logic [1:0]             o_rsp_err,
    output logic                   o_awvalid,
    input  logic                   i_awready,
    output logic [ADDR_W-1:0]      o_awaddress,
    output logic [2:0]             o_awprot,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    output logic [DATA_W-1:0]      o_wdata,
    output logic [DATA_W/8-1:0]    o_wstrb,
    input  logic                   i_bvalid,
    output logic                   o_bready,
    input  logic [1:0]             i_bresp,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    output logic [ADDR_W-1:0]      o_araddress,
    output logic [2:0]             o_arprot,
    input  logic                   i_rvalid,
    output logic                   o_rready,
    input  logic [DATA_W-1:0]      i_rdata,
    input  logic [1:0]             i_rresp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    state_e              r_state, w_state_next;
    logic [CH_W-1:0]     r_ch;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_done, r_w_done, r_timed_out;
    logic [WD_W-1:0]     r_wd;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_err;

    logic [N_CH-1:0]     w_grant;
    logic                w_grant_any;
    logic [CH_W-1:0]     w_sel;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [1:0]          w_sel_size;
    logic [2:0]          w_align_mask;
    logic                w_sel_bad;
    logic                w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_any_hs;
    logic                w_wait, w_wd_fire;
    logic [ADDR_W-1:0]   w_addr_aligned;
    logic [2:0]          w_prot;
    logic [STRB_W-1:0]   w_strb_base;
    logic [DATA_W-1:0]   w_rshift, w_ext;
    logic                w_sign;
    int                  w_nbits;

    assign w_grant_any = (r_state == StIdle) && (|i_req_valid);

    axi_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req_valid),
        .i_advance (w_grant_any),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) w_sel = CH_W'(i);
        end
    end

    assign w_sel_addr = i_req_addr[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_size = i_req_size[w_sel*2 +: 2];

    always_comb begin
        unique case (w_sel_size)
            SIZE_B:  w_align_mask = 3'd0;
            SIZE_H:  w_align_mask = 3'd1;
            SIZE_W:  w_align_mask = 3'd3;
            default: w_align_mask = 3'd7;
        endcase
    end

    assign w_sel_bad = ((w_sel_addr[2:0] & w_align_mask) != 3'd0) ||
                       ((w_sel_size == SIZE_D) && (DATA_W != 64));

    assign w_ar_hs  = o_arvalid && i_arready;
    assign w_r_hs   = (r_state == StR) && i_rvalid;
    assign w_aw_hs  = o_awvalid && i_awready;
    assign w_w_hs   = o_wvalid && i_wready;
    assign w_b_hs   = (r_state == StB) && i_bvalid;
    assign w_any_hs = w_ar_hs || w_r_hs || w_aw_hs || w_w_hs || w_b_hs;

    assign w_wait    = (r_state == StAr) || (r_state == StR) ||
                       (r_state == StAwW) || (r_state == StB);
    // Timeout is reported once; the transaction itself is still driven to completion.
    assign w_wd_fire = w_wait && !r_timed_out && !w_any_hs && (r_wd == WD_W'(TIMEOUT - 1));

    assign w_addr_aligned = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_prot         = CH_PROT[r_ch*3 +: 3];

    always_comb begin
        unique case (r_size)
            SIZE_B:  w_strb_base = STRB_W'(8'h01);
            SIZE_H:  w_strb_base = STRB_W'(8'h03);
            SIZE_W:  w_strb_base = STRB_W'(8'h0F);
            default: w_strb_base = STRB_W'(8'hFF);
        endcase
    end

    always_comb begin
        w_rshift = i_rdata >> {r_addr[OFF_W-1:0], 3'b000};
        unique case (r_size)
            SIZE_B:  begin w_nbits = 8;      w_sign = w_rshift[7];        end
            SIZE_H:  begin w_nbits = 16;     w_sign = w_rshift[15];       end
            SIZE_W:  begin w_nbits = 32;     w_sign = w_rshift[31];       end
            default: begin w_nbits = DATA_W; w_sign = w_rshift[DATA_W-1]; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            w_ext[i] = (i < w_nbits) ? w_rshift[i] : (r_signed & w_sign);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_bready     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_any) begin
                    if (w_sel_bad)              w_state_next = StErr;
                    else if (i_req_write[w_sel]) w_state_next = StAwW;
                    else                        w_state_next = StAr;
                end
            end
            StAr: begin
                o_arvalid = 1'b1;
                if (w_ar_hs) w_state_next = StR;
            end
            StR: begin
                o_rready = 1'b1;
                if (w_r_hs) w_state_next = r_timed_out ? StIdle : StRsp;
            end
            StAwW: begin
                o_awvalid = !r_aw_done;
                o_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = StB;
            end
            StB: begin
                o_bready = 1'b1;
                if (w_b_hs) w_state_next = r_timed_out ? StIdle : StRsp;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ch        <= '0;
            r_addr      <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_wdata     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_timed_out <= 1'b0;
            r_wd        <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
        end else begin
            if (w_grant_any) begin
                r_ch        <= w_sel;
                r_addr      <= w_sel_addr;
                r_size      <= w_sel_size;
                r_signed    <= i_req_signed[w_sel];
                r_wdata     <= i_req_wdata[w_sel*DATA_W +: DATA_W];
                r_aw_done   <= 1'b0;
                r_w_done    <= 1'b0;
                r_timed_out <= 1'b0;
            end else begin
                if (w_aw_hs)   r_aw_done   <= 1'b1;
                if (w_w_hs)    r_w_done    <= 1'b1;
                if (w_wd_fire) r_timed_out <= 1'b1;
            end
            if ((w_state_next != r_state) || w_any_hs) begin
                r_wd <= '0;
            end else if (w_wait && (r_wd != WD_W'(TIMEOUT - 1))) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_r_hs) begin
                if ((i_rresp == RESP_OKAY) || (i_rresp == RESP_EXOKAY)) begin
                    r_rsp_rdata <= w_ext;
                    r_rsp_err   <= ERR_OK;
                end else begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= ERR_BUS;
                end
            end
            if (w_b_hs) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= ((i_bresp == RESP_SLVERR) || (i_bresp == RESP_DECERR)) ?
                               ERR_BUS : ERR_OK;
            end
        end
    end

    assign o_req_ready = ((r_state == StIdle) && !i_reset) ? w_grant : '0;

    assign o_araddress = (r_state == StAr) ? w_addr_aligned : '0;
    assign o_arprot    = (r_state == StAr) ? w_prot : 3'b000;
    assign o_awaddress = (r_state == StAwW) ? w_addr_aligned : '0;
    assign o_awprot    = (r_state == StAwW) ? w_prot : 3'b000;
    assign o_wdata     = (r_state == StAwW) ? (r_wdata << {r_addr[OFF_W-1:0], 3'b000}) : '0;
    assign o_wstrb     = (r_state == StAwW) ? (w_strb_base << r_addr[OFF_W-1:0]) : '0;

    assign o_rsp_valid = ((r_state == StRsp) || (r_state == StErr) || w_wd_fire) ?
                         (N_CH'(1) << r_ch) : '0;
    assign o_rsp_rdata = (r_state == StRsp) ? r_rsp_rdata : '0;
    assign o_rsp_err   = (r_state == StErr) ? ERR_MISALIGN :
                         w_wd_fire          ? ERR_TIMEOUT  :
                         (r_state == StRsp) ? r_rsp_err    : ERR_OK;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: zero-wait slave model with knobs for
// stalls and error responses, plus a negedge monitor that records bus activity.
module tb_axi_lite_master;

    localparam int N_CH    = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH-1:0]        req_valid, req_ready, req_write, req_signed, rsp_valid;
    logic [2*N_CH-1:0]      req_size;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]      rsp_rdata, wdata, rdata;
    logic [1:0]             rsp_err, bresp, rresp;
    logic                   awvalid, awready, wvalid, wready, bvalid, bready;
    logic                   arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0]      awaddress, araddress;
    logic [2:0]             awprot, arprot;
    logic [DATA_W/8-1:0]    wstrb;

    always #5 clk = ~clk;

    axi_lite_master #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_write  (req_write),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_awvalid    (awvalid),
        .i_awready    (awready),
        .o_awaddress  (awaddress),
        .o_awprot     (awprot),
        .o_wvalid     (wvalid),
        .i_wready     (wready),
        .o_wdata      (wdata),
        .o_wstrb      (wstrb),
        .i_bvalid     (bvalid),
        .o_bready     (bready),
        .i_bresp      (bresp),
        .o_arvalid    (arvalid),
        .i_arready    (arready),
        .o_araddress  (araddress),
        .o_arprot     (arprot),
        .i_rvalid     (rvalid),
        .o_rready     (rready),
        .i_rdata      (rdata),
        .i_rresp      (rresp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave knobs
    logic              slv_arready = 1'b1;
    logic [DATA_W-1:0] slv_rdata   = '0;
    logic [1:0]        slv_rresp   = 2'b00;
    logic [1:0]        slv_bresp   = 2'b00;

    // Monitor state
    int                cyc = 0;
    int                grants[$];
    int                multi_grant = 0;
    int                grant_cyc = 0, rsp_cyc = 0, ar_first = -1;
    int                rsp_cnt = 0, r_cnt = 0;
    logic [N_CH-1:0]   last_rsp_vec;
    logic [DATA_W-1:0] last_rdata, last_wdata;
    logic [1:0]        last_err;
    logic [ADDR_W-1:0] last_araddr, last_awaddr;
    logic [2:0]        last_arprot, last_awprot;
    logic [3:0]        last_wstrb;
    logic              ar_hs_f = 0, r_hs_f = 0, aw_hs_f = 0, w_hs_f = 0, b_hs_f = 0;
    logic              aw_got = 0, w_got = 0;

    assign arready = slv_arready;
    assign awready = 1'b1;
    assign wready  = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ar_hs_f = !reset && arvalid && arready;
        r_hs_f  = !reset && rvalid && rready;
        aw_hs_f = !reset && awvalid && awready;
        w_hs_f  = !reset && wvalid && wready;
        b_hs_f  = !reset && bvalid && bready;
        if (!reset) begin
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1) multi_grant++;
                for (int i = 0; i < N_CH; i++) if (req_ready[i]) grants.push_back(i);
                grant_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                last_rsp_vec = rsp_valid;
                last_rdata   = rsp_rdata;
                last_err     = rsp_err;
                rsp_cyc      = cyc;
            end
            if (arvalid && ar_first < 0) ar_first = cyc;
            if (ar_hs_f) begin last_araddr = araddress; last_arprot = arprot; end
            if (aw_hs_f) begin last_awaddr = awaddress; last_awprot = awprot; end
            if (w_hs_f)  begin last_wdata = wdata; last_wstrb = wstrb; end
            if (r_hs_f)  r_cnt++;
        end
    end

    // Zero-wait slave: responds the cycle after the address/data handshakes.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            rvalid = 0; bvalid = 0; aw_got = 0; w_got = 0;
        end else begin
            if (r_hs_f) rvalid = 0;
            if (ar_hs_f) begin rvalid = 1; rdata = slv_rdata; rresp = slv_rresp; end
            if (b_hs_f) bvalid = 0;
            if (aw_hs_f) aw_got = 1;
            if (w_hs_f)  w_got = 1;
            if (aw_got && w_got) begin
                bvalid = 1; bresp = slv_bresp; aw_got = 0; w_got = 0;
            end
        end
    end

    task automatic issue(input int ch, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n0;
        n0 = grants.size();
        req_write[ch]           = wr;
        req_size[2*ch +: 2]     = sz;
        req_signed[ch]          = sgn;
        req_addr[ch*32 +: 32]   = addr;
        req_wdata[ch*32 +: 32]  = wd;
        ar_first                = -1;
        req_valid[ch]           = 1'b1;
        for (int k = 0; k < 50 && grants.size() == n0; k++) begin
            @(posedge clk); #1;
        end
        req_valid[ch] = 1'b0;
        check("grant_seen", grants.size() - n0, 1);
    endtask

    task automatic wait_rsp(input int n0, input int budget, input string tag);
        for (int k = 0; k < budget && rsp_cnt == n0; k++) begin
            @(posedge clk); #1;
        end
        check(tag, rsp_cnt - n0, 1);
    endtask

    int n0, n1, g0, r0;
    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        reset = 1; req_valid = '0; req_write = '0; req_size = '0; req_signed = '0;
        req_addr = '0; req_wdata = '0; rvalid = 0; bvalid = 0; rdata = '0;
        rresp = 2'b00; bresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
        check("rst_addr_data", {araddress, awaddress, wdata, wstrb}, 0);
        reset = 0;
        repeat (2) @(posedge clk);
        #1;

        // ch0 LW @0x100
        slv_rdata = 32'hDEADBEEF; n0 = rsp_cnt;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h100, 0);
        wait_rsp(n0, 40, "t1_rsp");
        check("t1_ar_lat", ar_first - grant_cyc, 1);
        check("t1_rsp_lat", rsp_cyc - grant_cyc, 3);
        check("t1_owner", last_rsp_vec, 2'b01);
        check("t1_rdata", last_rdata, 32'hDEADBEEF);
        check("t1_err", last_err, 2'b00);
        check("t1_araddr", last_araddr, 32'h100);
        check("t1_arprot", last_arprot, 3'b101);

        // ch1 SB @0x103
        n0 = rsp_cnt;
        issue(1, 1'b1, 2'd0, 1'b0, 32'h103, 32'hA5);
        wait_rsp(n0, 40, "t2_rsp");
        check("t2_wstrb", last_wstrb, 4'b1000);
        check("t2_wdata", last_wdata, 32'hA500_0000);
        check("t2_awprot", last_awprot, 3'b000);
        check("t2_awaddr", last_awaddr, 32'h100);
        check("t2_err", last_err, 2'b00);
        check("t2_owner", last_rsp_vec, 2'b10);
        check("t2_rsp_lat", rsp_cyc - grant_cyc, 3);
        check("t2_rdata_zero", last_rdata, 0);

        // ch1 LH @0x102 signed/unsigned, LBU @0x101, LB @0x103, SH @0x102
        slv_rdata = 32'h8001_0000; n0 = rsp_cnt;
        issue(1, 1'b0, 2'd1, 1'b1, 32'h102, 0);
        wait_rsp(n0, 40, "t3a_rsp");
        check("t3a_lh_signed", last_rdata, 32'hFFFF_8001);
        n0 = rsp_cnt;
        issue(1, 1'b0, 2'd1, 1'b0, 32'h102, 0);
        wait_rsp(n0, 40, "t3b_rsp");
        check("t3b_lhu", last_rdata, 32'h0000_8001);
        slv_rdata = 32'h1234_5678; n0 = rsp_cnt;
        issue(1, 1'b0, 2'd0, 1'b0, 32'h101, 0);
        wait_rsp(n0, 40, "t3c_rsp");
        check("t3c_lbu", last_rdata, 32'h0000_0056);
        slv_rdata = 32'h8000_0000; n0 = rsp_cnt;
        issue(1, 1'b0, 2'd0, 1'b1, 32'h103, 0);
        wait_rsp(n0, 40, "t3d_rsp");
        check("t3d_lb_signed", last_rdata, 32'hFFFF_FF80);
        n0 = rsp_cnt;
        issue(1, 1'b1, 2'd1, 1'b0, 32'h102, 32'hBEEF);
        wait_rsp(n0, 40, "t3e_rsp");
        check("t3e_wstrb", last_wstrb, 4'b1100);
        check("t3e_wdata", last_wdata, 32'hBEEF_0000);

        // Both channels continuously valid: alternate grants
        req_write = '0; req_size = 4'b1010; req_signed = '0;
        req_addr = {32'h4, 32'h0};
        g0 = grants.size(); n0 = rsp_cnt;
        req_valid = 2'b11;
        for (int k = 0; k < 100 && grants.size() < g0 + 4; k++) begin
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        for (int k = 0; k < 40 && rsp_cnt < n0 + 4; k++) begin
            @(posedge clk); #1;
        end
        check("t4_rsp_count", rsp_cnt - n0, 4);
        check("t4_grant_count", grants.size() - g0, 4);
        for (int k = 0; k < 4; k++) begin
            if (grants.size() > g0 + k) check($sformatf("t4_grant%0d", k), grants[g0+k], exp_order[k]);
        end
        check("t4_multi_grant", multi_grant, 0);

        // Misaligned LW and illegal 64-bit access, then a store with SLVERR
        n0 = rsp_cnt;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h101, 0);
        wait_rsp(n0, 20, "t5a_rsp");
        check("t5a_err", last_err, 2'b10);
        check("t5a_lat", rsp_cyc - grant_cyc, 1);
        check("t5a_no_ar", ar_first < 0, 1);
        n0 = rsp_cnt;
        issue(0, 1'b0, 2'd3, 1'b0, 32'h100, 0);
        wait_rsp(n0, 20, "t5b_rsp");
        check("t5b_err", last_err, 2'b10);
        check("t5b_no_ar", ar_first < 0, 1);
        slv_bresp = 2'b10; n0 = rsp_cnt;
        issue(1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1);
        wait_rsp(n0, 40, "t5c_rsp");
        check("t5c_err", last_err, 2'b01);
        slv_bresp = 2'b00;

        // Watchdog: arready stalled
        slv_arready = 1'b0; n0 = rsp_cnt; r0 = r_cnt;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h300, 0);
        wait_rsp(n0, TIMEOUT + 10, "t6_rsp");
        check("t6_err", last_err, 2'b11);
        check("t6_lat", rsp_cyc - grant_cyc, TIMEOUT);
        check("t6_owner", last_rsp_vec, 2'b01);
        n1 = rsp_cnt;
        @(posedge clk); #1;
        slv_arready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_late_rsp", rsp_cnt - n1, 0);
        check("t6_late_r_taken", r_cnt - r0, 1);
        check("t6_idle_bus", {arvalid, rready}, 2'b00);
        slv_rdata = 32'h0BAD_F00D; n0 = rsp_cnt;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h8, 0);
        wait_rsp(n0, 40, "t6b_rsp");
        check("t6b_rdata", last_rdata, 32'h0BAD_F00D);
        check("t6b_err", last_err, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
